// File: rtl/writeback_stage_ctrl.sv
// M/W pipeline latch and writeback controller: drives the single regfile write port
// from the latched instruction or from a 1-entry skid buffer holding late multdiv results.
module writeback_stage_ctrl #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned RA_REG       = 31,
    parameter int unsigned STATUS_REG   = 30,
    parameter int unsigned MD_EXC_CODE  = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_pc_plus1,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_AW-1:0] md_rd,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_stall_req
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [REG_AW-1:0] RA_ADDR     = REG_AW'(RA_REG);
    localparam logic [REG_AW-1:0] STATUS_ADDR = REG_AW'(STATUS_REG);
    localparam logic [DATA_W-1:0] EXC_DATA    = DATA_W'(MD_EXC_CODE);
    localparam logic [CNT_W-1:0]  CNT_LIMIT   = CNT_W'(STARVE_LIMIT);

    // W latch contents
    logic              valid_r;
    logic [31:0]       instr_r;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] mem_r;
    logic [DATA_W-1:0] pc1_r;
    logic              done_r;

    // skid buffer and starvation counter
    logic              skid_full_r;
    logic [REG_AW-1:0] skid_addr_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CNT_W-1:0]  starve_cnt_r;

    // decode and arbitration
    logic              dec_we_s;
    logic [REG_AW-1:0] dec_addr_s;
    logic [DATA_W-1:0] dec_data_s;
    logic              starve_s;
    logic              pipe_wr_s;
    logic              skid_drain_s;
    logic              md_accept_s;
    logic              sel_we_s;
    logic [REG_AW-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              write_ok_s;

    // W latch: reset > flush > stall > load; done remembers a write already made under stall
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= 1'b0;
            instr_r <= 32'h0000_0000;
            alu_r   <= '0;
            mem_r   <= '0;
            pc1_r   <= '0;
            done_r  <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else if (stall) begin
            done_r  <= done_r | pipe_wr_s;
        end else begin
            valid_r <= in_valid;
            instr_r <= in_instr;
            alu_r   <= in_alu_result;
            mem_r   <= in_mem_data;
            pc1_r   <= in_pc_plus1;
            done_r  <= 1'b0;
        end
    end

    // Decode the latched opcode into a candidate register write
    always_comb begin
        dec_we_s   = 1'b0;
        dec_addr_s = '0;
        dec_data_s = '0;
        case (instr_r[31:27])
            OP_RTYPE, OP_ADDI: begin
                dec_we_s   = 1'b1;
                dec_addr_s = instr_r[26:22];
                dec_data_s = alu_r;
            end
            OP_LW: begin
                dec_we_s   = 1'b1;
                dec_addr_s = instr_r[26:22];
                dec_data_s = mem_r;
            end
            OP_JAL: begin
                dec_we_s   = 1'b1;
                dec_addr_s = RA_ADDR;
                dec_data_s = pc1_r;
            end
            OP_SETX: begin
                dec_we_s   = 1'b1;
                dec_addr_s = STATUS_ADDR;
                dec_data_s = DATA_W'(instr_r[26:0]);
            end
            default: begin
                dec_we_s   = 1'b0;
                dec_addr_s = '0;
                dec_data_s = '0;
            end
        endcase
    end

    assign starve_s     = skid_full_r & (starve_cnt_r == CNT_LIMIT);
    assign pipe_wr_s    = valid_r & dec_we_s & ~done_r & ~starve_s;
    assign skid_drain_s = skid_full_r & ~pipe_wr_s;
    assign md_accept_s  = md_valid & md_ready;

    // Skid buffer: capture only on handshake, empty when it wins the port
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_full_r <= 1'b0;
            skid_addr_r <= '0;
            skid_data_r <= '0;
        end else if (md_accept_s) begin
            skid_full_r <= 1'b1;
            skid_addr_r <= md_exception ? STATUS_ADDR : md_rd;
            skid_data_r <= md_exception ? EXC_DATA : md_result;
        end else if (skid_drain_s) begin
            skid_full_r <= 1'b0;
        end else begin
            skid_full_r <= skid_full_r;
        end
    end

    // Starvation counter: cycles a full skid loses the port to the pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_r <= '0;
        end else if (skid_drain_s) begin
            starve_cnt_r <= '0;
        end else if (skid_full_r & pipe_wr_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Port arbitration: pipeline first, then skid, else idle
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = '0;
        sel_data_s = '0;
        if (pipe_wr_s) begin
            sel_we_s   = 1'b1;
            sel_addr_s = dec_addr_s;
            sel_data_s = dec_data_s;
        end else if (skid_full_r) begin
            sel_we_s   = 1'b1;
            sel_addr_s = skid_addr_r;
            sel_data_s = skid_data_r;
        end else begin
            sel_we_s   = 1'b0;
        end
    end

    // Register 0 is never written; nothing leaves the block while reset is held
    assign write_ok_s = sel_we_s & (sel_addr_s != '0) & ~reset;

    // Output drive
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (write_ok_s) begin
            rf_we    = 1'b1;
            rf_waddr = sel_addr_s;
            rf_wdata = sel_data_s;
        end else begin
            rf_we    = 1'b0;
        end
    end

    assign md_ready     = ~skid_full_r & ~reset;
    assign wb_stall_req = starve_s & ~reset;

endmodule

// File: tb/tb_writeback_stage_ctrl.sv
// Directed bench for writeback_stage_ctrl with hand-computed expectations.
module tb_writeback_stage_ctrl;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [31:0] in_pc_plus1;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        md_exception;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_stall_req;

    int tests_run;
    int tests_failed;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    writeback_stage_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .in_pc_plus1   (in_pc_plus1),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_rd         (md_rd),
        .md_result     (md_result),
        .md_exception  (md_exception),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .wb_stall_req  (wb_stall_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check_val({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
        check_val({tag, ".addr"}, {27'd0, rf_waddr}, {27'd0, addr});
        check_val({tag, ".data"}, rf_wdata, data);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [21:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc1);
        in_valid      = 1'b1;
        in_instr      = instr;
        in_alu_result = alu;
        in_mem_data   = mem;
        in_pc_plus1   = pc1;
    endtask

    task automatic md_send(input logic [4:0] rd, input logic [31:0] res, input logic exc);
        md_valid     = 1'b1;
        md_rd        = rd;
        md_result    = res;
        md_exception = exc;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_instr = 32'd0; in_alu_result = 32'd0;
        in_mem_data = 32'd0; in_pc_plus1 = 32'd0;
        md_valid = 1'b0; md_rd = 5'd0; md_result = 32'd0; md_exception = 1'b0;

        tick();
        tick();
        check_wr("reset", 1'b0, 5'd0, 32'd0);
        check_val("reset.md_ready", {31'd0, md_ready}, 32'd0);
        check_val("reset.stall_req", {31'd0, wb_stall_req}, 32'd0);
        reset = 1'b0;
        #1;
        check_val("idle.md_ready", {31'd0, md_ready}, 32'd1);

        // add $3 = 0x15
        load(mk(OP_RTYPE, 5'd3, 22'd0), 32'h15, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        check_wr("add", 1'b1, 5'd3, 32'h15);
        tick();
        check_wr("add.after", 1'b0, 5'd0, 32'd0);

        // jal then 3 stalled cycles: one write only
        load(mk(OP_JAL, 5'd7, 22'd0), 32'h99, 32'h0, 32'h40);
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        check_wr("jal", 1'b1, 5'd31, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("jal.stalled.we", {31'd0, rf_we}, 32'd0);
        end
        stall = 1'b0;
        tick();

        // multdiv in idle cycle
        md_send(5'd5, 32'd7, 1'b0);
        check_val("md.ready_before", {31'd0, md_ready}, 32'd1);
        tick();
        md_valid = 1'b0;
        check_val("md.ready_full", {31'd0, md_ready}, 32'd0);
        check_wr("md.write", 1'b1, 5'd5, 32'd7);
        tick();
        check_val("md.ready_again", {31'd0, md_ready}, 32'd1);
        check_val("md.after.we", {31'd0, rf_we}, 32'd0);

        // starvation: md accepted alongside an addi stream
        md_send(5'd6, 32'h66, 1'b0);
        load(mk(OP_ADDI, 5'd1, 22'd0), 32'h11, 32'h0, 32'h0);
        tick();
        md_valid = 1'b0;
        check_wr("starve.a", 1'b1, 5'd1, 32'h11);
        check_val("starve.a.req", {31'd0, wb_stall_req}, 32'd0);
        load(mk(OP_ADDI, 5'd2, 22'd0), 32'h22, 32'h0, 32'h0);
        tick();
        check_wr("starve.b", 1'b1, 5'd2, 32'h22);
        check_val("starve.b.req", {31'd0, wb_stall_req}, 32'd0);
        load(mk(OP_ADDI, 5'd3, 22'd0), 32'h33, 32'h0, 32'h0);
        tick();
        check_wr("starve.c", 1'b1, 5'd3, 32'h33);
        check_val("starve.c.req", {31'd0, wb_stall_req}, 32'd0);
        load(mk(OP_ADDI, 5'd4, 22'd0), 32'h44, 32'h0, 32'h0);
        tick();
        check_val("starve.req", {31'd0, wb_stall_req}, 32'd1);
        check_wr("starve.skid", 1'b1, 5'd6, 32'h66);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        in_valid = 1'b0;
        check_wr("starve.deferred", 1'b1, 5'd4, 32'h44);
        check_val("starve.req_clear", {31'd0, wb_stall_req}, 32'd0);
        check_val("starve.md_ready", {31'd0, md_ready}, 32'd1);
        tick();
        check_val("starve.after.we", {31'd0, rf_we}, 32'd0);

        // multdiv exception redirects to status register
        md_send(5'd9, 32'h123, 1'b1);
        tick();
        md_valid = 1'b0;
        md_exception = 1'b0;
        check_wr("md_exc", 1'b1, 5'd30, 32'd4);
        tick();
        check_val("md_exc.after.we", {31'd0, rf_we}, 32'd0);

        // lw to $0 suppressed, lw to $7 writes load data
        load(mk(OP_LW, 5'd0, 22'd0), 32'h1, 32'hAB, 32'h0);
        tick();
        check_val("lw0.we", {31'd0, rf_we}, 32'd0);
        load(mk(OP_LW, 5'd7, 22'd0), 32'h1, 32'hAB, 32'h0);
        tick();
        check_wr("lw7", 1'b1, 5'd7, 32'hAB);

        // setx writes zero-extended instr[26:0]
        load(mk(OP_SETX, 5'd1, 22'h234567), 32'h0, 32'h0, 32'h0);
        tick();
        check_wr("setx", 1'b1, 5'd30, 32'h0063_4567);

        // unknown opcode and flushed instruction both produce no write
        load(mk(5'b11111, 5'd4, 22'd0), 32'h5, 32'h5, 32'h5);
        tick();
        check_val("badop.we", {31'd0, rf_we}, 32'd0);
        load(mk(OP_ADDI, 5'd8, 22'd0), 32'h88, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_val("flush.we", {31'd0, rf_we}, 32'd0);
        tick();

        // reset with a full skid and a valid latch
        md_send(5'd12, 32'h5, 1'b0);
        load(mk(OP_ADDI, 5'd10, 22'd0), 32'hA0, 32'h0, 32'h0);
        tick();
        md_valid = 1'b0;
        in_valid = 1'b0;
        check_wr("prereset", 1'b1, 5'd10, 32'hA0);
        reset = 1'b1;
        #1;
        check_val("inreset.we", {31'd0, rf_we}, 32'd0);
        check_val("inreset.md_ready", {31'd0, md_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_wr("postreset", 1'b0, 5'd0, 32'd0);
        check_val("postreset.req", {31'd0, wb_stall_req}, 32'd0);
        check_val("postreset.md_ready", {31'd0, md_ready}, 32'd1);
        tick();
        check_val("postreset.noskid.we", {31'd0, rf_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
